rib_dma: RTL and testbench

RIB_DMA -- requirements
Module: rib_dma

---
 rtl/rib_dma_pkg.sv | 24 ++
 rtl/rib_dma.sv | 121 ++++++++++++
 tb/tb_rib_dma.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rib_dma_pkg.sv
// Shared RIB definitions: DMA engine state encoding and bus constants.
package rib_dma_pkg;

  // state     | meaning
  // ----------+-----------------------------------------------
  // IDLE      | waiting for a start command
  // RD_REQ    | read request on the bus, waiting for grant
  // RD_RSP    | read granted, waiting for read data
  // WR_REQ    | write request on the bus, waiting for grant
  // WR_RSP    | write granted, waiting for write response
  // DONE      | one-cycle completion pulse
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_REQ = 3'd1;
  localparam logic [2:0] ST_RD_RSP = 3'd2;
  localparam logic [2:0] ST_WR_REQ = 3'd3;
  localparam logic [2:0] ST_WR_RSP = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [3:0]  RIB_MASK_FULL  = 4'hF;
  localparam logic [31:0] RIB_STRIDE     = 32'd4;
  // Word alignment: the engine only ever issues whole-word accesses.
  localparam logic [31:0] RIB_WORD_ALIGN = 32'hFFFF_FFFC;

endpackage

// File: rtl/rib_dma.sv
// Single-channel word-copy DMA engine on a RIB initiator port.
// Each word is one read followed by one write; no timeout on the bus.
module rib_dma
  import rib_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_ribm_addr,
  output logic             o_ribm_wrcs,
  output logic [3:0]       o_ribm_mask,
  output logic [31:0]      o_ribm_wdata,
  input  logic [31:0]      i_ribm_rdata,
  output logic             o_ribm_req,
  input  logic             i_ribm_gnt,
  input  logic             i_ribm_rsp,
  output logic             o_ribm_rdy
);

  logic [2:0]       state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] cnt_q;

  // Transfer sequencing: state, address pointers, data holding register and remaining count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              src_q   <= i_src & RIB_WORD_ALIGN;
              dst_q   <= i_dst & RIB_WORD_ALIGN;
              cnt_q   <= i_len;
              state_q <= ST_RD_REQ;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_RD_REQ: begin
          if (i_ribm_gnt) state_q <= ST_RD_RSP;
        end
        ST_RD_RSP: begin
          if (i_ribm_rsp) begin
            data_q  <= i_ribm_rdata;
            state_q <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (i_ribm_gnt) state_q <= ST_WR_RSP;
        end
        ST_WR_RSP: begin
          if (i_ribm_rsp) begin
            src_q   <= src_q + RIB_STRIDE;
            dst_q   <= dst_q + RIB_STRIDE;
            cnt_q   <= cnt_q - LEN_W'(1);
            // Last word when the count is about to hit zero.
            state_q <= (cnt_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus outputs are decoded from state so the request stays stable until granted.
  always_comb begin
    o_ribm_req   = 1'b0;
    o_ribm_rdy   = 1'b0;
    o_ribm_wrcs  = 1'b0;
    o_ribm_mask  = 4'h0;
    o_ribm_addr  = 32'h0;
    o_ribm_wdata = 32'h0;
    case (state_q)
      ST_RD_REQ: begin
        o_ribm_req  = 1'b1;
        o_ribm_mask = RIB_MASK_FULL;
        o_ribm_addr = src_q;
      end
      ST_RD_RSP: begin
        o_ribm_rdy = 1'b1;
      end
      ST_WR_REQ: begin
        o_ribm_req   = 1'b1;
        o_ribm_wrcs  = 1'b1;
        o_ribm_mask  = RIB_MASK_FULL;
        o_ribm_addr  = dst_q;
        o_ribm_wdata = data_q;
      end
      ST_WR_RSP: begin
        o_ribm_rdy = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_rib_dma.sv
// Self-checking bench for rib_dma: directed scenarios plus randomized copies
// against a word-level copy model and a configurable-latency RIB responder.
module tb_rib_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done;
  logic [31:0] addr, wdata, rdata;
  logic        wrcs, req, gnt, rsp, rdy;
  logic [3:0]  mask;

  int n_checks = 0;
  int n_errors = 0;

  rib_dma #(.LEN_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_src(src), .i_dst(dst), .i_len(len),
    .o_busy(busy), .o_done(done),
    .o_ribm_addr(addr), .o_ribm_wrcs(wrcs), .o_ribm_mask(mask), .o_ribm_wdata(wdata),
    .i_ribm_rdata(rdata), .o_ribm_req(req), .i_ribm_gnt(gnt), .i_ribm_rsp(rsp),
    .o_ribm_rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder: memory of 256 words indexed by addr[9:2], grant after gnt_dly
  // waiting cycles, response rsp_dly cycles after the cycle following grant.
  logic [31:0] mem  [0:255];
  logic [31:0] mref [0:255];
  logic        load_mem = 1'b0;
  logic        spur = 1'b0;
  int          gnt_dly = 0;
  int          rsp_dly = 0;
  int          wcnt = 0;
  int          rcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] rd_q = 32'h0;
  logic [64:0] txn_log [$];

  assign gnt   = req && (wcnt >= gnt_dly);
  assign rsp   = (pend && (rcnt >= rsp_dly)) || spur;
  assign rdata = rd_q;

  // Responder state and memory.
  always @(posedge clk) begin
    if (load_mem) for (int i = 0; i < 256; i++) mem[i] <= mref[i];
    if (rst) begin
      pend <= 1'b0;
      wcnt <= 0;
      rcnt <= 0;
    end else if (req && gnt) begin
      wcnt <= 0;
      pend <= 1'b1;
      rcnt <= 0;
      if (wrcs) mem[addr[9:2]] <= wdata;
      else      rd_q <= mem[addr[9:2]];
      txn_log.push_back({wrcs, addr, wrcs ? wdata : 32'h0});
    end else begin
      wcnt <= req ? wcnt + 1 : 0;
      if (pend) begin
        if (rsp && rdy) pend <= 1'b0;
        else            rcnt <= rcnt + 1;
      end
    end
  end

  // Protocol monitor: done/req counters and request-stability / mask rules.
  int          done_cnt = 0;
  int          req_cnt = 0;
  int          proto_err = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  logic        p_wrcs = 1'b0;
  always @(negedge clk) begin
    logic bad;
    bad = 1'b0;
    if (done) done_cnt <= done_cnt + 1;
    if (req)  req_cnt  <= req_cnt + 1;
    if (req && (mask !== 4'hF || addr[1:0] !== 2'b00)) bad = 1'b1;
    if (req && rdy) bad = 1'b1;
    if (!rst && prev_wait &&
        (req !== 1'b1 || addr !== p_addr || wdata !== p_wdata || wrcs !== p_wrcs)) bad = 1'b1;
    if (bad) proto_err <= proto_err + 1;
    prev_wait <= req && !gnt && !rst;
    p_addr    <= addr;
    p_wdata   <= wdata;
    p_wrcs    <= wrcs;
  end

  // One copy command; expectations come from a word-by-word copy model.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int gd, input int rd, input int xs, input bit sp);
    logic [64:0] expq [$];
    logic [31:0] a, w, v;
    int t, exp_t, d0, r0;
    w = 32'h0;
    gnt_dly = gd;
    rsp_dly = rd;
    if (sp) begin
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      a = (s & 32'hFFFF_FFFC) + 32'(4 * i);
      w = (d & 32'hFFFF_FFFC) + 32'(4 * i);
      v = mref[a[9:2]];
      expq.push_back({1'b0, a, 32'h0});
      expq.push_back({1'b1, w, v});
      mref[w[9:2]] = v;
    end
    exp_t = 1 + n * (4 + 2 * gd + 2 * rd);
    txn_log.delete();
    d0 = done_cnt;
    r0 = req_cnt;
    src = s; dst = d; len = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (done !== 1'b1 && t < 3000) begin
      start = (xs != 0 && t == xs);
      src = $urandom; dst = $urandom; len = 16'($urandom_range(1, 9));
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("done_cycle", 65'(t), 65'(exp_t));
    @(negedge clk);
    check("busy_after_done", {64'h0, busy}, 65'h0);
    check("done_one_cycle", {64'h0, done}, 65'h0);
    repeat (3) @(negedge clk);
    check("done_count", 65'(done_cnt - d0), 65'd1);
    if (n == 0) check("zero_len_no_req", 65'(req_cnt - r0), 65'd0);
    check("txn_count", 65'(txn_log.size()), 65'(expq.size()));
    for (int i = 0; i < expq.size() && i < txn_log.size(); i++)
      check($sformatf("txn%0d", i), txn_log[i], expq[i]);
    if (n > 0) check("mem_last_dst", {33'h0, mem[w[9:2]]}, {33'h0, mref[w[9:2]]});
  endtask

  initial begin
    int t, d0;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < 256; i++) mref[i] = $urandom;
    mref[8'h40] = 32'hDEAD_BEEF;
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    check("reset_outputs", {26'h0, busy, done, req, rdy, wrcs, mask, addr},  65'h0);
    check("reset_wdata", {33'h0, wdata}, 65'h0);
    rst = 1'b0;
    @(negedge clk);

    // single word, zero-wait
    run_xfer(32'h100, 32'h200, 1, 0, 0, 0, 1'b0);
    check("single_word_data", {33'h0, mem[8'h80]}, {33'h0, 32'hDEAD_BEEF});
    // burst with grant backpressure
    run_xfer(32'h100, 32'h200, 4, 2, 0, 0, 1'b0);
    // zero length, with a stray response in idle
    run_xfer(32'h100, 32'h200, 0, 0, 0, 0, 1'b1);
    // address wrap
    run_xfer(32'hFFFF_FFFC, 32'h300, 2, 0, 0, 0, 1'b0);
    // start while busy
    run_xfer(32'h043, 32'h381, 3, 1, 1, 4, 1'b0);

    // reset in WR_REQ
    gnt_dly = 2; rsp_dly = 0;
    d0 = done_cnt;
    src = 32'h20; dst = 32'h240; len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(req && wrcs) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_wr_req", {64'h0, req && wrcs}, 65'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {64'h0, req}, 65'h0);
    check("rst_mid_busy", {64'h0, busy}, 65'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", 65'(done_cnt - d0), 65'd0);
    run_xfer(32'h20, 32'h240, 3, 0, 0, 0, 1'b0);

    // randomized copies
    for (int k = 0; k < 12; k++) begin
      int n;
      n = $urandom_range(0, 5);
      run_xfer($urandom, $urandom, n, $urandom_range(0, 3), $urandom_range(0, 2),
               (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : 0,
               1'($urandom_range(0, 1)));
    end

    check("protocol_rules", 65'(proto_err), 65'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
